// File: rtl/led_matrix_scan_pkg.sv
// led_matrix_scan_pkg: shared geometry constants and the scan FSM state encoding.
package led_matrix_scan_pkg;
    localparam int LED_NCOLS = 16;
    localparam int LED_NROWS = 10;
    localparam int FONT_AW   = 6;

    typedef enum logic [1:0] {
        S_SHOW  = 2'd0,
        S_BLANK = 2'd1,
        S_FETCH = 2'd2
    } state_e;
endpackage

// File: rtl/led_tick_edge.sv
// led_tick_edge: one-cycle tick on each rising edge of the 1 ms square wave.
module led_tick_edge (
    input  logic clk,
    input  logic rst,
    input  logic clk1ms_i,
    output logic tick_o
);
    logic clk1ms_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) clk1ms_prev_q <= 1'b0;
        else     clk1ms_prev_q <= clk1ms_i;
    end

    assign tick_o = clk1ms_i & ~clk1ms_prev_q;
endmodule

// File: rtl/led_matrix_scan.sv
// led_matrix_scan: column-multiplexed LED scan with anti-ghost blanking and a scroll offset.
// Define LED_SCROLL_BOUNCE_EN to make the offset ping-pong between 0 and 2**AW-NCOLS.
module led_matrix_scan
    import led_matrix_scan_pkg::*;
#(
    parameter int NCOLS     = LED_NCOLS,
    parameter int NROWS     = LED_NROWS,
    parameter int AW        = FONT_AW,
    parameter int SCROLL_MS = 100,
    parameter int BLANK_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk1ms,
    input  logic             pause,
    output logic [AW-1:0]    radr,
    input  logic [NROWS-1:0] dat,
    output logic [NCOLS-1:0] col,
    output logic [NROWS-1:0] row,
    output logic             frame_start,
    output logic [AW-1:0]    offset
);
    localparam int CW = $clog2(NCOLS);
    localparam int MW = SCROLL_MS > 1 ? $clog2(SCROLL_MS) : 1;
    localparam int BW = $clog2(BLANK_CYC + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d, idx_nxt;
    logic [MW-1:0]    ms_q, ms_d;
    logic [BW-1:0]    blank_q, blank_d;
    logic [AW-1:0]    radr_q, radr_d, off_q, off_d, off_step;
    logic [NROWS-1:0] row_q, row_d;
    logic             first_q, first_d, pend_q, pend_d, fs_q, fs_d;
    logic             tick, lit, ms_wrap, apply;

    led_tick_edge u_tick (
        .clk      (clk),
        .rst      (rst),
        .clk1ms_i (clk1ms),
        .tick_o   (tick)
    );

    // Nothing is lit until the first tick after reset has fetched column 0.
    assign lit     = state_q == S_SHOW && !first_q;
    assign ms_wrap = tick && ms_q == MW'(SCROLL_MS - 1);
    assign idx_nxt = (first_q || idx_q == CW'(NCOLS - 1)) ? '0 : idx_q + 1'b1;
    assign apply   = tick && lit && idx_q == CW'(NCOLS - 1) && pend_q && !pause;

`ifdef LED_SCROLL_BOUNCE_EN
    localparam logic [AW-1:0] TOP = AW'(2 ** AW - NCOLS);
    logic dir_q, dir_d;

    assign off_step = dir_q ? off_q - 1'b1 : off_q + 1'b1;
    assign dir_d    = (apply && (off_step == TOP || off_step == '0)) ? ~dir_q : dir_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dir_q <= 1'b0;
        else     dir_q <= dir_d;
    end
`else
    assign off_step = off_q + 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        first_d = first_q;
        radr_d  = radr_q;
        row_d   = row_q;
        blank_d = blank_q;
        fs_d    = 1'b0;
        ms_d    = tick ? (ms_wrap ? '0 : ms_q + 1'b1) : ms_q;
        pend_d  = pause ? pend_q : ms_wrap ? 1'b1 : apply ? 1'b0 : pend_q;
        off_d   = apply ? off_step : off_q;
        unique case (state_q)
            S_SHOW: if (tick) begin
                state_d = S_BLANK;
                idx_d   = idx_nxt;
                first_d = 1'b0;
                blank_d = '0;
                radr_d  = off_d + AW'(idx_nxt);
            end
            S_BLANK: begin
                blank_d = blank_q + 1'b1;
                state_d = blank_q == BW'(BLANK_CYC) ? S_FETCH : S_BLANK;
            end
            S_FETCH: begin
                row_d   = dat;
                fs_d    = idx_q == '0;
                state_d = S_SHOW;
            end
            default: state_d = S_SHOW;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_SHOW;
            idx_q   <= '0;
            first_q <= 1'b1;
            radr_q  <= '0;
            row_q   <= '0;
            blank_q <= '0;
            fs_q    <= 1'b0;
            ms_q    <= '0;
            pend_q  <= 1'b0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            radr_q  <= radr_d;
            row_q   <= row_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
            ms_q    <= ms_d;
            pend_q  <= pend_d;
            off_q   <= off_d;
        end
    end

    assign col         = lit ? NCOLS'(1) << idx_q : '0;
    assign row         = lit ? row_q : '0;
    assign radr        = radr_q;
    assign offset      = off_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan: directed checks of scan order, blanking, scroll, pause, wrap/bounce and reset.
module tb_led_matrix_scan;
    localparam int BLANK = 4;

    logic        clk = 1'b0, rst = 1'b0, clk1ms = 1'b0, pause = 1'b0;
    logic [5:0]  radr, offset, exp_off;
    logic [9:0]  dat, row;
    logic [15:0] col;
    logic        frame_start, dir;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;
    assign dat = {4'b0, radr};

    led_matrix_scan #(.SCROLL_MS(2), .BLANK_CYC(BLANK)) dut (
        .clk         (clk),
        .rst         (rst),
        .clk1ms      (clk1ms),
        .pause       (pause),
        .radr        (radr),
        .dat         (dat),
        .col         (col),
        .row         (row),
        .frame_start (frame_start),
        .offset      (offset)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One tick: outputs must stay dark through blank+fetch, then column k shows ROM[off+k].
    task automatic tick_chk(input int k, input logic [5:0] off);
        logic       quiet;
        logic [5:0] a;
        quiet = 1'b1;
        a = off + 6'(k);
        @(negedge clk);
        clk1ms = 1'b1;
        @(posedge clk);
        for (int i = 0; i < BLANK + 2; i++) begin
            #1 if (col !== '0 || row !== '0 || frame_start !== 1'b0) quiet = 1'b0;
            @(posedge clk);
        end
        #1;
        chk("blank", 32'(quiet), 32'(1'b1));
        chk("col", 32'(col), 32'(16'h1 << k));
        chk("row", 32'(row), 32'({4'b0, a}));
        chk("offset", 32'(offset), 32'(off));
        chk("frame_start", 32'(frame_start), 32'(k == 0));
        @(posedge clk);
        #1 chk("fs_width", 32'(frame_start), 32'(1'b0));
        @(negedge clk);
        clk1ms = 1'b0;
    endtask

    task automatic run_frame(input logic [5:0] off);
        for (int k = 0; k < 16; k++) tick_chk(k, off);
    endtask

    initial begin
        logic quiet;
        #2 rst = 1'b1;
        #1;
        chk("rst_col", 32'(col), 32'h0);
        chk("rst_row", 32'(row), 32'h0);
        chk("rst_radr", 32'(radr), 32'h0);
        chk("rst_offset", 32'(offset), 32'h0);
        chk("rst_fs", 32'(frame_start), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_frame(6'd0);
        run_frame(6'd1);
        pause = 1'b1;
        repeat (3) run_frame(6'd1);
        pause = 1'b0;
        run_frame(6'd2);
        exp_off = 6'd2;
        dir = 1'b0;
`ifdef LED_SCROLL_BOUNCE_EN
        repeat (96) begin
            exp_off = dir ? exp_off - 1'b1 : exp_off + 1'b1;
            if (exp_off == 6'd48 || exp_off == 6'd0) dir = ~dir;
            run_frame(exp_off);
        end
`else
        repeat (63) begin
            exp_off = exp_off + 1'b1;
            run_frame(exp_off);
        end
`endif
        chk("final_offset", 32'(offset), 32'(exp_off));
        @(negedge clk);
        clk1ms = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_col", 32'(col), 32'h0);
        chk("mid_row", 32'(row), 32'h0);
        chk("mid_radr", 32'(radr), 32'h0);
        chk("mid_offset", 32'(offset), 32'h0);
        chk("mid_fs", 32'(frame_start), 32'h0);
        clk1ms = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (BLANK + 4) begin
            @(posedge clk);
            #1 if (col !== '0 || row !== '0) quiet = 1'b0;
        end
        chk("no_partial", 32'(quiet), 32'(1'b1));
        tick_chk(0, 6'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
